// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified instruction/data memory between
// the fetch stage (IF) and the load/store unit (DM). One access at a time,
// wait states absorbed through mem_ready, stall outputs for the pipeline.
//
// Optional build macro: ARB_FAIRNESS_EN
//   undefined : strict DM-over-IF priority, no starvation counter
//   defined   : after STARVE_MAX consecutive DM grants made while a fetch
//               waits, the next arbitration goes to IF
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch the winner's request
// WAIT  | access on the memory port; mem_en only in the first cycle,
//       | leave on mem_ready (honoured from the first cycle onward)
// RESP  | owner's valid pulses; no arbitration here, back to IDLE
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory macro port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // pipeline control
  output logic              stall_if,
  output logic              stall_mem
);

  // The starvation counter is 4 bits wide, so the limit must fit in 1..15.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_dm;   // 1 = DM owns the access, 0 = IF
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_load;       // grant made this cycle (IDLE only)
  logic              w_done;       // memory signalled completion (WAIT only)
  logic              w_grant_dm;   // arbitration result, meaningful with w_load

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_force_if;

  // A fetch that has watched STARVE_MAX data grants in a row wins next.
  assign w_force_if = if_req && (r_starve_cnt == LP_STARVE);
  assign w_grant_dm = dm_req && !w_force_if;

  // Count DM grants taken while a fetch waits; any IF grant clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_load) begin
      if (!w_grant_dm) begin
        r_starve_cnt <= 4'd0;
      end else if (if_req && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  // The data request belongs to the older instruction, so it always wins.
  assign w_grant_dm = dm_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the grant/complete strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the winner's request; the memory sees it unchanged until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner_dm  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_load;
      if (w_load) begin
        r_owner_dm <= w_grant_dm;
        r_mem_we   <= w_grant_dm && dm_we;
        r_mem_addr <= w_grant_dm ? dm_addr : if_addr;
        if (w_grant_dm) begin
          r_mem_wdata <= dm_wdata;
        end
      end
    end
  end

  // Capture read data into the owner's register; stores leave both untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (w_done && !r_mem_we) begin
      if (r_owner_dm) begin
        r_dm_rdata <= mem_rdata;
      end else begin
        r_if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign if_valid  = (r_state == S_RESP) && !r_owner_dm;
  assign dm_valid  = (r_state == S_RESP) &&  r_owner_dm;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: scoreboard of expected grants and responses,
// behavioural memory with programmable wait states.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  grant_t      q_grant[$];
  logic [31:0] q_ifv[$];
  logic [31:0] q_dmv[$];

  int          wait_cfg   = 0;
  int          rem        = -1;
  logic        tie_ready  = 1'b1;
  logic [31:0] last_dm_rd = 32'h0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign mem_rdata = model_rd(mem_addr);
  assign mem_ready = tie_ready | (rem == 0);

  // Memory: ready comes wait_cfg cycles after the mem_en cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en)       rem = wait_cfg;
      else if (rem > 0) rem = rem - 1;
      else              rem = -1;
    end
  end

  // Scoreboard: every grant and every valid must match the queued expectation.
  logic prev_en = 1'b0;
  initial begin
    grant_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_en) begin
          vectors++;
          if (prev_en) begin
            miscompares++;
            $display("FAIL mem_en_pulse: mem_en high 2 cycles, required 1");
          end
          if (q_grant.size() == 0) begin
            miscompares++;
            $display("FAIL grant: unexpected grant addr=%h we=%b", mem_addr, mem_we);
          end else begin
            e = q_grant.pop_front();
            if (mem_addr !== e.addr || mem_we !== e.we || (e.we && mem_wdata !== e.wdata)) begin
              miscompares++;
              $display("FAIL grant: got addr=%h we=%b wd=%h, required addr=%h we=%b wd=%h",
                       mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
            end
          end
        end
        if (if_valid) begin
          vectors++;
          if (q_ifv.size() == 0) begin
            miscompares++;
            $display("FAIL if_valid: unexpected pulse, if_rdata=%h", if_rdata);
          end else begin
            d = q_ifv.pop_front();
            if (if_rdata !== d) begin
              miscompares++;
              $display("FAIL if_rdata: got %h, required %h", if_rdata, d);
            end
          end
        end
        if (dm_valid) begin
          vectors++;
          if (q_dmv.size() == 0) begin
            miscompares++;
            $display("FAIL dm_valid: unexpected pulse, dm_rdata=%h", dm_rdata);
          end else begin
            d = q_dmv.pop_front();
            if (dm_rdata !== d) begin
              miscompares++;
              $display("FAIL dm_rdata: got %h, required %h", dm_rdata, d);
            end
          end
        end
      end
      prev_en = mem_en && reset_n;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = i[0]; dm_req = i[1]; dm_we = i[0]; if_addr = 32'h40 + i; dm_addr = 32'h80 + i;
      #1;
      vectors++;
      if ({mem_en, mem_we, if_valid, dm_valid} !== 4'b0 || mem_addr !== 32'h0 ||
          mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: en=%b we=%b ifv=%b dmv=%b addr=%h wd=%h ifr=%h dmr=%h, required all 0",
                 mem_en, mem_we, if_valid, dm_valid, mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      vectors++;
      if (stall_if !== if_req) begin
        miscompares++;
        $display("FAIL reset_stall_if: got %b, required %b", stall_if, if_req);
      end
    end
    @(negedge clk);
    dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    q_grant.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0});
    q_ifv.push_back(model_rd(32'h10));
    reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++;
      if (mem_en !== (c == 1) || if_valid !== (c == 2)) begin
        miscompares++;
        $display("FAIL first_fetch_c%0d: mem_en=%b if_valid=%b, required %b %b",
                 c, mem_en, if_valid, c == 1, c == 2);
      end
      if (if_valid) if_req = 1'b0;
    end
    tie_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    wait_cfg = 3;
    q_grant.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
    last_dm_rd = model_rd(32'h200);
    q_dmv.push_back(last_dm_rd);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vectors++;
      if (c <= 4) begin
        if (mem_en !== (c == 1) || mem_addr !== 32'h200 || dm_valid !== 1'b0 || stall_mem !== 1'b1) begin
          miscompares++;
          $display("FAIL wait_c%0d: en=%b addr=%h dmv=%b stall_mem=%b, required %b 00000200 0 1",
                   c, mem_en, mem_addr, dm_valid, stall_mem, c == 1);
        end
      end else begin
        if (dm_valid !== (c == 5) || stall_mem !== 1'b0 || mem_en !== 1'b0) begin
          miscompares++;
          $display("FAIL wait_c%0d: dmv=%b stall_mem=%b en=%b, required %b 0 0",
                   c, dm_valid, stall_mem, mem_en, c == 5);
        end
      end
      if (dm_valid) dm_req = 1'b0;
    end
  endtask

  task automatic test_collision();
    bit done = 0;
    @(negedge clk);
    wait_cfg = 1;
    q_grant.push_back('{addr: 32'h104, we: 1'b1, wdata: 32'hDEAD_BEEF});
    q_grant.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0});
    q_dmv.push_back(last_dm_rd);
    q_ifv.push_back(model_rd(32'h80));
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h104; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      vectors++;
      if (stall_if !== !if_valid) begin
        miscompares++;
        $display("FAIL collision_stall_if: got %b, required %b", stall_if, !if_valid);
      end
      if (dm_valid) dm_req = 1'b0;
      if (if_valid) begin if_req = 1'b0; done = 1; end
    end
    vectors++;
    if (!done || dm_rdata !== last_dm_rd) begin
      miscompares++;
      $display("FAIL collision_end: done=%b dm_rdata=%h, required 1 %h", done, dm_rdata, last_dm_rd);
    end
    dm_we = 1'b0;
  endtask

  task automatic test_fairness();
    int g = 0;
    @(negedge clk);
    wait_cfg = 0;
`ifdef ARB_FAIRNESS_EN
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) begin
        q_grant.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
        q_ifv.push_back(model_rd(32'h40));
      end else begin
        q_grant.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
        q_dmv.push_back(model_rd(32'h300));
      end
    end
    last_dm_rd = model_rd(32'h300);
`else
    for (int i = 0; i < 6; i++) begin
      q_grant.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
      q_dmv.push_back(model_rd(32'h300));
    end
    last_dm_rd = model_rd(32'h300);
`endif
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int c = 0; c < 200 && g < 6; c++) begin
      @(negedge clk);
`ifndef ARB_FAIRNESS_EN
      vectors++;
      if (stall_if !== 1'b1 || if_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL strict_priority: stall_if=%b if_valid=%b, required 1 0", stall_if, if_valid);
      end
`endif
      if (mem_en) g++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    vectors++;
    if (g != 6) begin
      miscompares++;
      $display("FAIL fairness_grants: got %0d grants, required 6", g);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_dropped_request();
    int n_valid = 0;
    int n_en = 0;
    @(negedge clk);
    wait_cfg = 2;
    q_grant.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
    q_ifv.push_back(model_rd(32'h44));
    if_req = 1'b1; if_addr = 32'h44;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_en) begin n_en++; if_req = 1'b0; end
      if (if_valid) n_valid++;
    end
    vectors++;
    if (n_valid != 1 || n_en != 1) begin
      miscompares++;
      $display("FAIL dropped_req: valid pulses=%0d grants=%0d, required 1 1", n_valid, n_en);
    end
  endtask

  task automatic test_reset_mid_access();
    int n_bad = 0;
    bit seen = 0;
    @(negedge clk);
    wait_cfg = 5;
    q_grant.push_back('{addr: 32'h280, we: 1'b0, wdata: 32'h0});
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h280;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_en) seen = 1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (!seen || mem_en !== 1'b0 || dm_valid !== 1'b0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: seen=%b en=%b dmv=%b addr=%h, required 1 0 0 00000000",
               seen, mem_en, dm_valid, mem_addr);
    end
    repeat (3) @(negedge clk);
    dm_req = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dm_valid || mem_en || if_valid) n_bad++;
    end
    vectors++;
    if (n_bad != 0) begin
      miscompares++;
      $display("FAIL reset_mid_after: %0d cycles with activity, required 0", n_bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_wait_states();
    test_collision();
    test_fairness();
    test_dropped_request();
    test_reset_mid_access();
    vectors++;
    if (q_grant.size() != 0 || q_ifv.size() != 0 || q_dmv.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: left grant=%0d ifv=%0d dmv=%0d, required 0 0 0",
               q_grant.size(), q_ifv.size(), q_dmv.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
